// File: rtl/frame_tx_ctrl.sv
// frame_tx_ctrl
// Sequences one RIFFA TX channel to return a processed frame to the host.
// Frame geometry is latched on CONF_END, the length in 32-bit words is
// computed and range-checked, the CHNL_TX request/ACK handshake runs, and a
// first-word-fall-through pixel FIFO is drained onto CHNL_TX_DATA until the
// computed number of 64-bit beats has been accepted by the host.
//
// Ports
//   CLK                 in   single clock; CHNL_TX_CLK is a copy of it
//   RST                 in   synchronous active-high reset
//   WIDTH, HEIGHT       in   frame geometry in pixels (valid with CONF_END)
//   CONF_END            in   one-cycle pulse: geometry valid
//   FIFO_DATA           in   FWFT FIFO head, pixel n in [31:0], n+1 in [63:32]
//   FIFO_EMPTY          in   FIFO empty
//   FIFO_REN            out  FIFO pop
//   CHNL_TX_CLK         out  equals CLK
//   CHNL_TX             out  transaction request
//   CHNL_TX_ACK         in   host acknowledge
//   CHNL_TX_LAST        out  constant 1
//   CHNL_TX_LEN         out  transfer length in 32-bit words
//   CHNL_TX_OFF         out  constant 0
//   CHNL_TX_DATA        out  equals FIFO_DATA
//   CHNL_TX_DATA_VALID  out  beat valid
//   CHNL_TX_DATA_REN    in   host accepts beat
//   BUSY                out  high in every state except IDLE
//   FRAME_DONE          out  one-cycle pulse after the final beat
//   CONF_ERR            out  one-cycle pulse: geometry rejected / CONF_END dropped
//
// Only C_PCI_DATA_WIDTH = 64 is supported (two 32-bit pixels per beat).

module frame_tx_ctrl #(
  parameter int          C_PCI_DATA_WIDTH = 64,
  parameter logic [31:0] C_MAX_WORDS      = 32'h0080_0000
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [31:0]                 WIDTH,
  input  logic [31:0]                 HEIGHT,
  input  logic                        CONF_END,
  input  logic [C_PCI_DATA_WIDTH-1:0] FIFO_DATA,
  input  logic                        FIFO_EMPTY,
  output logic                        FIFO_REN,
  output logic                        CHNL_TX_CLK,
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic                        CHNL_TX_LAST,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [30:0]                 CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN,
  output logic                        BUSY,
  output logic                        FRAME_DONE,
  output logic                        CONF_ERR
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_REQ  = 3'd2,
    S_XFER = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] width_q, width_d;
  logic [31:0] height_q, height_d;
  logic [31:0] len_q, len_d;
  logic [31:0] beats_q, beats_d;
  logic [31:0] count_q, count_d;
  logic        chnl_tx_q, chnl_tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [63:0] words_s;
  logic [63:0] words_rnd_s;
  logic        reject_s;
  logic        drop_s;
  logic        valid_s;
  logic        beat_s;
  logic        last_beat_s;

  // Full 64-bit product so that oversize geometry can never wrap into range.
  assign words_s     = {32'd0, width_q} * {32'd0, height_q};
  assign words_rnd_s = words_s + 64'd1;
  assign reject_s    = (words_s == 64'd0) || (words_s > {32'd0, C_MAX_WORDS});

  // CONF_END outside IDLE (including the DONE cycle) is dropped and flagged.
  assign drop_s      = CONF_END && (state_q != S_IDLE);

  // The FIFO is first-word-fall-through, so its head is offered directly and a
  // beat is consumed only when the host takes it.
  assign valid_s     = (state_q == S_XFER) && !FIFO_EMPTY;
  assign beat_s      = valid_s && CHNL_TX_DATA_REN;
  assign last_beat_s = (count_q == (beats_q - 32'd1));

  assign CHNL_TX_CLK        = CLK;
  assign CHNL_TX_LAST       = 1'b1;
  assign CHNL_TX_OFF        = 31'd0;
  assign CHNL_TX_DATA       = FIFO_DATA;
  assign CHNL_TX_DATA_VALID = valid_s;
  assign FIFO_REN           = beat_s;
  assign CHNL_TX            = chnl_tx_q;
  assign CHNL_TX_LEN        = len_q;
  assign BUSY               = busy_q;
  assign FRAME_DONE         = done_q;
  assign CONF_ERR           = err_q;

  // Next-state and datapath update for the transmit sequencer.
  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    len_d    = len_q;
    beats_d  = beats_q;
    count_d  = count_q;
    err_d    = drop_s;

    case (state_q)
      S_IDLE: begin
        if (CONF_END) begin
          width_d  = WIDTH;
          height_d = HEIGHT;
          state_d  = S_CALC;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_CALC: begin
        if (reject_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          len_d   = words_s[31:0];
          // ceil(words/2): an odd word count still needs a whole final beat.
          beats_d = words_rnd_s[32:1];
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (CHNL_TX_ACK) begin
          state_d = S_XFER;
        end else begin
          state_d = S_REQ;
        end
      end

      S_XFER: begin
        if (beat_s && last_beat_s) begin
          count_d = 32'd0;
          state_d = S_DONE;
        end else if (beat_s) begin
          count_d = count_q + 32'd1;
        end else begin
          count_d = count_q;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        count_d = 32'd0;
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered from the state being entered so that they
    // line up with the state register without a decode glitch.
    chnl_tx_d = (state_d == S_REQ) || (state_d == S_XFER);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      width_q   <= 32'd0;
      height_q  <= 32'd0;
      len_q     <= 32'd0;
      beats_q   <= 32'd0;
      count_q   <= 32'd0;
      chnl_tx_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      len_q     <= len_d;
      beats_q   <= beats_d;
      count_q   <= count_d;
      chnl_tx_q <= chnl_tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_frame_tx_ctrl.sv
// tb_frame_tx_ctrl
// Directed bench for frame_tx_ctrl. A small FWFT FIFO model supplies a known
// word pattern; a monitor records every accepted beat so beat count, pop count
// and data order can be compared against hand-computed values.

module tb_frame_tx_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] WIDTH;
  logic [31:0] HEIGHT;
  logic        CONF_END;
  logic [63:0] FIFO_DATA;
  logic        FIFO_EMPTY;
  logic        FIFO_REN;
  logic        CHNL_TX_CLK;
  logic        CHNL_TX;
  logic        CHNL_TX_ACK;
  logic        CHNL_TX_LAST;
  logic [31:0] CHNL_TX_LEN;
  logic [30:0] CHNL_TX_OFF;
  logic [63:0] CHNL_TX_DATA;
  logic        CHNL_TX_DATA_VALID;
  logic        CHNL_TX_DATA_REN;
  logic        BUSY;
  logic        FRAME_DONE;
  logic        CONF_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  // FIFO model: entry i holds a fixed pattern, so expected data is a formula.
  int   rd_ptr = 0;
  int   wr_ptr = 0;
  logic hold_empty;

  // Monitor state.
  logic [63:0] rx [0:63];
  int          rx_cnt = 0;
  int          viol   = 0;

  always #5 CLK = ~CLK;

  frame_tx_ctrl dut (
    .CLK                (CLK),
    .RST                (RST),
    .WIDTH              (WIDTH),
    .HEIGHT             (HEIGHT),
    .CONF_END           (CONF_END),
    .FIFO_DATA          (FIFO_DATA),
    .FIFO_EMPTY         (FIFO_EMPTY),
    .FIFO_REN           (FIFO_REN),
    .CHNL_TX_CLK        (CHNL_TX_CLK),
    .CHNL_TX            (CHNL_TX),
    .CHNL_TX_ACK        (CHNL_TX_ACK),
    .CHNL_TX_LAST       (CHNL_TX_LAST),
    .CHNL_TX_LEN        (CHNL_TX_LEN),
    .CHNL_TX_OFF        (CHNL_TX_OFF),
    .CHNL_TX_DATA       (CHNL_TX_DATA),
    .CHNL_TX_DATA_VALID (CHNL_TX_DATA_VALID),
    .CHNL_TX_DATA_REN   (CHNL_TX_DATA_REN),
    .BUSY               (BUSY),
    .FRAME_DONE         (FRAME_DONE),
    .CONF_ERR           (CONF_ERR)
  );

  function automatic logic [63:0] pat(input int i);
    logic [31:0] lo;
    logic [31:0] hi;
    lo  = 32'hA000_0000 + 32'(2 * i);
    hi  = 32'hA000_0000 + 32'(2 * i + 1);
    pat = {hi, lo};
  endfunction

  assign FIFO_DATA  = pat(rd_ptr);
  assign FIFO_EMPTY = hold_empty || (rd_ptr >= wr_ptr);

  // FIFO pop on the edge that sees FIFO_REN.
  always @(posedge CLK) begin
    if (FIFO_REN) rd_ptr <= rd_ptr + 1;
  end

  // Record accepted beats and any VALID asserted over an empty FIFO.
  always @(posedge CLK) begin
    if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
      if (rx_cnt < 64) rx[rx_cnt] = CHNL_TX_DATA;
      rx_cnt = rx_cnt + 1;
    end
    if (CHNL_TX_DATA_VALID && FIFO_EMPTY) viol = viol + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Rejected geometry: CONF_ERR one cycle after CALC, no request, LEN kept.
  task automatic err_case(input logic [31:0] w, input logic [31:0] h,
                          input logic [31:0] prev_len, input string tag);
    WIDTH = w; HEIGHT = h; CONF_END = 1'b1;
    step();
    CONF_END = 1'b0;
    check_eq({tag, "_err_early"}, 64'(CONF_ERR), 64'd0);
    step();
    check_eq({tag, "_err"},  64'(CONF_ERR), 64'd1);
    check_eq({tag, "_busy"}, 64'(BUSY), 64'd0);
    check_eq({tag, "_tx"},   64'(CHNL_TX), 64'd0);
    check_eq({tag, "_len"},  64'(CHNL_TX_LEN), 64'(prev_len));
    step();
    check_eq({tag, "_err_clr"}, 64'(CONF_ERR), 64'd0);
    check_eq({tag, "_tx_idle"}, 64'(CHNL_TX), 64'd0);
  endtask

  // mode 0 plain, 1 FIFO gaps + host stalls, 2 extra CONF_END mid-frame,
  // 3 reset after beat 2.
  task automatic run_frame(input logic [31:0] w, input logic [31:0] h,
                           input int mode, input string tag);
    int          start;
    int          rx_base;
    int          viol_base;
    logic [31:0] exp_len;
    int          exp_beats;
    logic        done_seen;
    exp_len   = w * h;
    exp_beats = int'((exp_len + 32'd1) >> 1);
    start     = rd_ptr;
    rx_base   = rx_cnt;
    viol_base = viol;
    wr_ptr    = rd_ptr + 16;
    done_seen = 1'b0;

    WIDTH = w; HEIGHT = h; CONF_END = 1'b1;
    step();
    CONF_END = 1'b0;
    check_eq({tag, "_busy_calc"}, 64'(BUSY), 64'd1);
    check_eq({tag, "_tx_calc"},   64'(CHNL_TX), 64'd0);
    step();
    check_eq({tag, "_tx_req"}, 64'(CHNL_TX), 64'd1);
    check_eq({tag, "_len"},    64'(CHNL_TX_LEN), 64'(exp_len));
    step();
    step();
    check_eq({tag, "_valid_req"}, 64'(CHNL_TX_DATA_VALID), 64'd0);
    CHNL_TX_ACK = 1'b1;
    step();
    CHNL_TX_ACK = 1'b0;

    for (int k = 0; k < 80 && !done_seen; k++) begin
      if (mode == 1) begin
        hold_empty       = (k % 2 == 1);
        CHNL_TX_DATA_REN = !(k >= 3 && k < 6);
      end
      if (mode == 2) begin
        CONF_END = (k == 1);
        if (k == 1) begin
          WIDTH = 32'd2; HEIGHT = 32'd2;
        end
      end
      if (mode == 3 && (rx_cnt - rx_base) >= 2) begin
        CHNL_TX_DATA_REN = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        CHNL_TX_DATA_REN = 1'b1;
        check_eq({tag, "_rst_tx"},    64'(CHNL_TX), 64'd0);
        check_eq({tag, "_rst_valid"}, 64'(CHNL_TX_DATA_VALID), 64'd0);
        check_eq({tag, "_rst_busy"},  64'(BUSY), 64'd0);
        check_eq({tag, "_rst_len"},   64'(CHNL_TX_LEN), 64'd0);
        check_eq({tag, "_rst_pops"},  64'(rd_ptr - start), 64'd2);
        return;
      end
      step();
      if (mode == 2 && k == 1) begin
        check_eq({tag, "_drop_err"}, 64'(CONF_ERR), 64'd1);
        check_eq({tag, "_drop_len"}, 64'(CHNL_TX_LEN), 64'(exp_len));
      end
      if (FRAME_DONE) done_seen = 1'b1;
    end
    hold_empty       = 1'b0;
    CHNL_TX_DATA_REN = 1'b1;
    CONF_END         = 1'b0;

    check_eq({tag, "_done_seen"}, 64'(done_seen), 64'd1);
    check_eq({tag, "_tx_done"},   64'(CHNL_TX), 64'd0);
    check_eq({tag, "_busy_done"}, 64'(BUSY), 64'd1);
    check_eq({tag, "_beats"},     64'(rx_cnt - rx_base), 64'(exp_beats));
    check_eq({tag, "_pops"},      64'(rd_ptr - start), 64'(exp_beats));
    check_eq({tag, "_viol"},      64'(viol - viol_base), 64'd0);
    for (int j = 0; j < exp_beats && j < 16; j++) begin
      check_eq({tag, "_data"}, rx[rx_base + j], pat(start + j));
    end
    step();
    check_eq({tag, "_done_clr"}, 64'(FRAME_DONE), 64'd0);
    check_eq({tag, "_idle"},     64'(BUSY), 64'd0);
  endtask

  initial begin
    RST = 1'b1;
    WIDTH = 32'd0; HEIGHT = 32'd0; CONF_END = 1'b0;
    CHNL_TX_ACK = 1'b0; CHNL_TX_DATA_REN = 1'b1;
    hold_empty = 1'b0;
    step(); step(); step();
    check_eq("rst_tx",    64'(CHNL_TX), 64'd0);
    check_eq("rst_valid", 64'(CHNL_TX_DATA_VALID), 64'd0);
    check_eq("rst_ren",   64'(FIFO_REN), 64'd0);
    check_eq("rst_len",   64'(CHNL_TX_LEN), 64'd0);
    check_eq("rst_busy",  64'(BUSY), 64'd0);
    check_eq("rst_done",  64'(FRAME_DONE), 64'd0);
    check_eq("rst_err",   64'(CONF_ERR), 64'd0);
    check_eq("rst_last",  64'(CHNL_TX_LAST), 64'd1);
    check_eq("rst_off",   64'(CHNL_TX_OFF), 64'd0);
    RST = 1'b0;
    step();

    run_frame(32'd4, 32'd2, 0, "f4x2");
    run_frame(32'd3, 32'd1, 0, "f3x1");
    err_case(32'd4, 32'd0, 32'd3, "h0");
    err_case(32'd4096, 32'd4096, 32'd3, "big");
    run_frame(32'd8, 32'd1, 1, "f8x1_gaps");
    run_frame(32'd4, 32'd2, 2, "f4x2_drop");
    run_frame(32'd4, 32'd2, 3, "f4x2_rst");
    step();
    run_frame(32'd2, 32'd2, 0, "f2x2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
